// File: rtl/onehot_grant_arbiter.sv
// -----------------------------------------------------------------------------
// onehot_grant_arbiter
//
// Two-state (IDLE/GRANT) arbiter with three selectable policies, sampled only
// while IDLE:
//   mode 00 : strict one-hot. Grants only when exactly one request is set.
//   mode 01 : fixed priority. Bit 0 has the highest priority.
//   mode 10 : round-robin. Picks the first set bit at or above rr_ptr,
//             wrapping to bit 0.
//   mode 11 : same as 01.
// A grant is held, without preemption, for as long as the holder keeps its
// request. When the holder releases, the block spends at least one cycle in
// IDLE before it can grant again. Separately, every cycle in which mode is 00
// and more than one request is set counts as a one-hot violation. The block
// reports each one as a registered pulse and counts them in a saturating
// counter.
//
// Ports
//   clk        in   1       single clock, rising edge
//   rst_n      in   1       asynchronous active-low reset
//   req        in   N_REQ   request vector, bit i = requester i
//   mode       in   2       arbitration mode (see above)
//   err_clr    in   1       synchronous clear of viol_cnt (wins over increment)
//   gnt_valid  out  1       a grant is held
//   gnt_onehot out  N_REQ   one-hot grant vector, zero when no grant
//   gnt_code   out  CODE_W  granted index + 1, zero when no grant
//   viol       out  1       registered one-hot violation flag
//   viol_cnt   out  CNT_W   saturating count of violation cycles
// -----------------------------------------------------------------------------
module onehot_grant_arbiter #(
    parameter  int N_REQ  = 4,
    parameter  int CNT_W  = 8,
    localparam int CODE_W = $clog2(N_REQ + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_REQ-1:0]  req,
    input  logic [1:0]        mode,
    input  logic              err_clr,
    output logic              gnt_valid,
    output logic [N_REQ-1:0]  gnt_onehot,
    output logic [CODE_W-1:0] gnt_code,
    output logic              viol,
    output logic [CNT_W-1:0]  viol_cnt
);

    localparam int IDX_W = $clog2(N_REQ);

    localparam logic [N_REQ-1:0] ONEHOT_LSB = {{(N_REQ-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t             state_q;
    logic [IDX_W-1:0]   holder_q;
    logic [IDX_W-1:0]   rr_ptr_q;
    logic               gnt_valid_q;
    logic [N_REQ-1:0]   gnt_onehot_q;
    logic [CODE_W-1:0]  gnt_code_q;
    logic               viol_q;
    logic               viol_d;
    logic [CNT_W-1:0]   viol_cnt_q;
    logic [CNT_W-1:0]   viol_cnt_d;

    logic [CODE_W-1:0]  pop_cnt;     // popcount of req
    logic               low_found;   // any request set
    logic [IDX_W-1:0]   low_idx;     // lowest set index
    logic               hi_found;    // any request at or above rr_ptr
    logic [IDX_W-1:0]   hi_idx;      // lowest set index at or above rr_ptr
    logic               pick_valid;  // IDLE would grant this cycle
    logic [IDX_W-1:0]   pick_idx;    // index IDLE would grant
    logic [IDX_W-1:0]   rr_next;     // (pick_idx + 1) mod N_REQ

    // Request scan: popcount, lowest set bit, and lowest set bit at or
    // above the round-robin pointer. Round-robin wrap falls back to the
    // plain lowest set bit when nothing sits at or above the pointer.
    always_comb begin
        // NOTE: every combinational output gets a default before any
        // conditional assignment so no path leaves it unassigned (no latch).
        pop_cnt   = '0;
        low_found = 1'b0;
        low_idx   = '0;
        hi_found  = 1'b0;
        hi_idx    = '0;
        for (int i = 0; i < N_REQ; i++) begin
            pop_cnt = pop_cnt + CODE_W'(req[i]);
            if (!low_found && req[i]) begin
                low_found = 1'b1;
                low_idx   = IDX_W'(i);
            end
            if (!hi_found && req[i] && (i >= int'(rr_ptr_q))) begin
                hi_found = 1'b1;
                hi_idx   = IDX_W'(i);
            end
        end
    end

    // Policy selection for the IDLE-state grant decision.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = low_idx;
        case (mode)
            2'b00: pick_valid = (pop_cnt == CODE_W'(1));
            2'b10: begin
                pick_valid = low_found;
                pick_idx   = hi_found ? hi_idx : low_idx;
            end
            default: pick_valid = low_found;
        endcase
    end

    assign rr_next = (pick_idx == IDX_W'(N_REQ - 1)) ? '0 : pick_idx + IDX_W'(1);

    // Violation detection runs in both states, independent of the FSM.
    assign viol_d = (mode == 2'b00) && (pop_cnt > CODE_W'(1));

    always_comb begin
        viol_cnt_d = viol_cnt_q;
        if (err_clr) begin
            viol_cnt_d = '0;
        end else if (viol_d && (viol_cnt_q != CNT_MAX)) begin
            viol_cnt_d = viol_cnt_q + CNT_W'(1);
        end
    end

    // FSM with registered grant outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: every state bit here is a plain control flop, so all of them
        // are reset asynchronously; a grant drops the moment rst_n falls.
        if (!rst_n) begin
            state_q      <= IDLE;
            holder_q     <= '0;
            rr_ptr_q     <= '0;
            gnt_valid_q  <= 1'b0;
            gnt_onehot_q <= '0;
            gnt_code_q   <= '0;
            viol_q       <= 1'b0;
            viol_cnt_q   <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the
            // pre-edge values regardless of statement order.
            viol_q     <= viol_d;
            viol_cnt_q <= viol_cnt_d;
            case (state_q)
                IDLE: begin
                    if (pick_valid) begin
                        state_q      <= GRANT;
                        holder_q     <= pick_idx;
                        rr_ptr_q     <= rr_next;
                        gnt_valid_q  <= 1'b1;
                        gnt_onehot_q <= ONEHOT_LSB << pick_idx;
                        gnt_code_q   <= CODE_W'(pick_idx) + CODE_W'(1);
                    end
                end
                GRANT: begin
                    // Held purely on the holder's own request: other bits
                    // and mode changes cannot disturb an active grant.
                    if (!req[holder_q]) begin
                        state_q      <= IDLE;
                        gnt_valid_q  <= 1'b0;
                        gnt_onehot_q <= '0;
                        gnt_code_q   <= '0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign gnt_valid  = gnt_valid_q;
    assign gnt_onehot = gnt_onehot_q;
    assign gnt_code   = gnt_code_q;
    assign viol       = viol_q;
    assign viol_cnt   = viol_cnt_q;

endmodule

// File: tb/tb_onehot_grant_arbiter.sv
// -----------------------------------------------------------------------------
// tb_onehot_grant_arbiter
//
// Directed bench for onehot_grant_arbiter (N_REQ=4, CNT_W=8). Each step drives
// the inputs and pushes the outputs expected after the next rising edge into
// a scoreboard queue. The bench then pops that entry and compares it against
// the outputs sampled 1 time unit after the edge.
// -----------------------------------------------------------------------------
module tb_onehot_grant_arbiter;

    localparam int N_REQ  = 4;
    localparam int CNT_W  = 8;
    localparam int CODE_W = 3;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [N_REQ-1:0]  req;
    logic [1:0]        mode;
    logic              err_clr;
    logic              gnt_valid;
    logic [N_REQ-1:0]  gnt_onehot;
    logic [CODE_W-1:0] gnt_code;
    logic              viol;
    logic [CNT_W-1:0]  viol_cnt;

    onehot_grant_arbiter #(
        .N_REQ (N_REQ),
        .CNT_W (CNT_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .mode       (mode),
        .err_clr    (err_clr),
        .gnt_valid  (gnt_valid),
        .gnt_onehot (gnt_onehot),
        .gnt_code   (gnt_code),
        .viol       (viol),
        .viol_cnt   (viol_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        string             tag;
        logic              valid;
        logic [CODE_W-1:0] code;
        logic              vflag;
        logic [CNT_W-1:0]  cnt;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic push_exp(input string tag, input logic v, input logic [CODE_W-1:0] c,
                            input logic vf, input logic [CNT_W-1:0] n);
        exp_t e;
        e.tag   = tag;
        e.valid = v;
        e.code  = c;
        e.vflag = vf;
        e.cnt   = n;
        sb.push_back(e);
    endtask

    task automatic pop_compare();
        exp_t             e;
        logic [N_REQ-1:0] oh;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL scoreboard_underflow observed=empty expected=entry");
            return;
        end
        e  = sb.pop_front();
        oh = (e.code == '0) ? '0 : (4'b0001 << (e.code - 3'd1));
        check({e.tag, ":gnt_valid"},  32'(gnt_valid),  32'(e.valid));
        check({e.tag, ":gnt_code"},   32'(gnt_code),   32'(e.code));
        check({e.tag, ":gnt_onehot"}, 32'(gnt_onehot), 32'(oh));
        check({e.tag, ":viol"},       32'(viol),       32'(e.vflag));
        check({e.tag, ":viol_cnt"},   32'(viol_cnt),   32'(e.cnt));
    endtask

    // Drive one cycle of stimulus and check the outputs after the edge.
    task automatic step(input string tag, input logic [N_REQ-1:0] r, input logic [1:0] m,
                        input logic clr, input logic v, input logic [CODE_W-1:0] c,
                        input logic vf, input logic [CNT_W-1:0] n);
        req     = r;
        mode    = m;
        err_clr = clr;
        push_exp(tag, v, c, vf, n);
        @(posedge clk);
        #1;
        pop_compare();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [N_REQ-1:0] drop;
        int               n;

        rst_n   = 1'b1;
        req     = '0;
        mode    = 2'b00;
        err_clr = 1'b0;
        #1 rst_n = 1'b0;
        #2;
        push_exp("reset", 1'b0, 3'd0, 1'b0, 8'd0);
        pop_compare();
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Strict one-hot: a single request is granted after one edge.
        step("oh_grant",   4'b0100, 2'b00, 1'b0, 1'b1, 3'd3, 1'b0, 8'd0);
        step("oh_release", 4'b0000, 2'b00, 1'b0, 1'b0, 3'd0, 1'b0, 8'd0);

        // Strict one-hot violation: no grant, and the counter climbs. err_clr
        // beats a simultaneous increment but leaves viol alone.
        step("viol_1",    4'b0110, 2'b00, 1'b0, 1'b0, 3'd0, 1'b1, 8'd1);
        step("viol_2",    4'b0110, 2'b00, 1'b0, 1'b0, 3'd0, 1'b1, 8'd2);
        step("viol_3",    4'b0110, 2'b00, 1'b0, 1'b0, 3'd0, 1'b1, 8'd3);
        step("viol_clr",  4'b0110, 2'b00, 1'b1, 1'b0, 3'd0, 1'b1, 8'd0);
        step("viol_done", 4'b0000, 2'b00, 1'b0, 1'b0, 3'd0, 1'b0, 8'd0);

        // Fixed priority without preemption; a mode change while held is ignored.
        step("fp_grant",   4'b1010, 2'b01, 1'b0, 1'b1, 3'd2, 1'b0, 8'd0);
        step("fp_hold",    4'b1011, 2'b01, 1'b0, 1'b1, 3'd2, 1'b0, 8'd0);
        step("fp_modechg", 4'b1011, 2'b10, 1'b0, 1'b1, 3'd2, 1'b0, 8'd0);
        step("fp_release", 4'b0000, 2'b01, 1'b0, 1'b0, 3'd0, 1'b0, 8'd0);

        // Mode 11 behaves as fixed priority.
        step("m11_grant",   4'b0110, 2'b11, 1'b0, 1'b1, 3'd2, 1'b0, 8'd0);
        step("m11_release", 4'b0000, 2'b11, 1'b0, 1'b0, 3'd0, 1'b0, 8'd0);

        // A grant to bit 3 leaves rr_ptr at 0 for the round-robin sequence.
        step("rr_setup",     4'b1000, 2'b01, 1'b0, 1'b1, 3'd4, 1'b0, 8'd0);
        step("rr_setup_rel", 4'b0000, 2'b01, 1'b0, 1'b0, 3'd0, 1'b0, 8'd0);

        // Round-robin with all requests held: order 1,2,3,4,1, dead cycle each.
        for (int k = 0; k < 5; k++) begin
            drop = 4'b1111 & ~(4'b0001 << (k % 4));
            step("rr_grant", 4'b1111, 2'b10, 1'b0, 1'b1, 3'((k % 4) + 1), 1'b0, 8'd0);
            step("rr_dead",  drop,    2'b10, 1'b0, 1'b0, 3'd0,            1'b0, 8'd0);
        end
        // rr_ptr is now 1. Only bit 0 requests, so the search wraps.
        step("rr_wrap",     4'b0001, 2'b10, 1'b0, 1'b1, 3'd1, 1'b0, 8'd0);
        step("rr_wrap_rel", 4'b0000, 2'b10, 1'b0, 1'b0, 3'd0, 1'b0, 8'd0);

        // Counter saturation.
        for (int i = 0; i < 300; i++) begin
            n = (i + 1 > 255) ? 255 : i + 1;
            step("sat", 4'b0011, 2'b00, 1'b0, 1'b0, 3'd0, 1'b1, 8'(n));
        end
        step("sat_hold", 4'b0000, 2'b00, 1'b0, 1'b0, 3'd0, 1'b0, 8'd255);

        // Reset asserted mid-grant clears everything without a clock edge.
        step("pre_rst_grant", 4'b0100, 2'b01, 1'b0, 1'b1, 3'd3, 1'b0, 8'd255);
        #2 rst_n = 1'b0;
        #1;
        push_exp("async_rst", 1'b0, 3'd0, 1'b0, 8'd0);
        pop_compare();
        @(posedge clk);
        #1 rst_n = 1'b1;
        step("post_rst_first", 4'b0001, 2'b01, 1'b0, 1'b1, 3'd1, 1'b0, 8'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
